// File: rtl/register_file_pkg.sv
// Shared widths and zero constants for the
// rename-aware architectural register file.
package register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int ROB_ID_W = 5;

  typedef logic [DATA_W-1:0]   DATA_TYPE;
  typedef logic [REG_W-1:0]    REG_POS_TYPE;
  typedef logic [ROB_ID_W-1:0] ROB_ID_TYPE;

  localparam DATA_TYPE    ZERO_WORD = '0;
  localparam ROB_ID_TYPE  ZERO_ROB  = '0;
  localparam REG_POS_TYPE ZERO_REG  = '0;

endpackage

// File: rtl/register_file_rf_read_port.sv
// One combinational read with commit bypass
// and x0 masking.
module rf_read_port
  import register_file_pkg::*;
(
  input  REG_POS_TYPE rs_i,
  input  ROB_ID_TYPE  tag_i,
  input  DATA_TYPE    val_i,
  input  logic        commit_i,
  input  REG_POS_TYPE rd_rob_i,
  input  ROB_ID_TYPE  q_rob_i,
  input  DATA_TYPE    v_rob_i,
  output ROB_ID_TYPE  q_o,
  output DATA_TYPE    v_o
);

  logic is_x0;
  logic bypass;

  assign is_x0  = (rs_i == ZERO_REG);
  assign bypass = commit_i
                & (rd_rob_i == rs_i)
                & (tag_i == q_rob_i);

  always_comb begin
    q_o = tag_i;
    v_o = val_i;
    unique case (1'b1)
      is_x0: begin
        q_o = ZERO_ROB;
        v_o = ZERO_WORD;
      end
      bypass: begin
        q_o = ZERO_ROB;
        v_o = v_rob_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// Architectural values plus pending ROB tags;
// rename, commit and misbranch flush.
module register_file
  import register_file_pkg::*;
#(
  parameter int REG_NUM      = 32,
  parameter int ROB_ID_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic [4:0]              rs1_from_dispatcher,
  input  logic [4:0]              rs2_from_dispatcher,
  output logic [ROB_ID_WIDTH-1:0] Q1_to_dispatcher,
  output logic [ROB_ID_WIDTH-1:0] Q2_to_dispatcher,
  output logic [31:0]             V1_to_dispatcher,
  output logic [31:0]             V2_to_dispatcher,
  input  logic                    rename_signal_from_dispatcher,
  input  logic [4:0]              rd_from_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0] rob_id_from_dispatcher,
  input  logic                    commit_flag_from_rob,
  input  logic [4:0]              rd_from_rob,
  input  logic [ROB_ID_WIDTH-1:0] Q_from_rob,
  input  logic [31:0]             V_from_rob,
  input  logic                    misbranch_flag_from_rob
);

  DATA_TYPE   val_q [REG_NUM];
  DATA_TYPE   val_d [REG_NUM];
  ROB_ID_TYPE tag_q [REG_NUM];
  ROB_ID_TYPE tag_d [REG_NUM];

  REG_POS_TYPE rs1, rs2, rd_dsp, rd_rob;
  ROB_ID_TYPE  q_rob, rob_id, q1, q2;
  DATA_TYPE    v_rob, v1, v2;
  logic        commit_en, rename_en;

  assign rs1    = rs1_from_dispatcher;
  assign rs2    = rs2_from_dispatcher;
  assign rd_dsp = rd_from_dispatcher;
  assign rd_rob = rd_from_rob;
  assign q_rob  = Q_from_rob;
  assign rob_id = rob_id_from_dispatcher;
  assign v_rob  = V_from_rob;

  // Bypass only when the commit will actually land this edge
  assign commit_en = commit_flag_from_rob & rdy & rst_n
                   & (rd_rob != ZERO_REG);
  assign rename_en = rename_signal_from_dispatcher
                   & (rd_dsp != ZERO_REG);

  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (commit_en) begin
      val_d[rd_rob] = v_rob;
      if (tag_q[rd_rob] == q_rob)
        tag_d[rd_rob] = ZERO_ROB;
    end
    if (rename_en)
      tag_d[rd_dsp] = rob_id;
    if (misbranch_flag_from_rob) begin
      for (int i = 0; i < REG_NUM; i++)
        tag_d[i] = ZERO_ROB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= ZERO_WORD;
        tag_q[i] <= ZERO_ROB;
      end
    end else if (rdy) begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  rf_read_port u_rd1 (
    .rs_i     (rs1),
    .tag_i    (tag_q[rs1]),
    .val_i    (val_q[rs1]),
    .commit_i (commit_en),
    .rd_rob_i (rd_rob),
    .q_rob_i  (q_rob),
    .v_rob_i  (v_rob),
    .q_o      (q1),
    .v_o      (v1)
  );

  rf_read_port u_rd2 (
    .rs_i     (rs2),
    .tag_i    (tag_q[rs2]),
    .val_i    (val_q[rs2]),
    .commit_i (commit_en),
    .rd_rob_i (rd_rob),
    .q_rob_i  (q_rob),
    .v_rob_i  (v_rob),
    .q_o      (q2),
    .v_o      (v2)
  );

  assign Q1_to_dispatcher = q1;
  assign Q2_to_dispatcher = q2;
  assign V1_to_dispatcher = v1;
  assign V2_to_dispatcher = v2;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, rename,
// commit bypass, flush, x0 and stall behaviour.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [4:0]  rs1, rs2;
  logic [4:0]  q1, q2;
  logic [31:0] v1, v2;
  logic        ren;
  logic [4:0]  rd_d;
  logic [4:0]  rob_id;
  logic        cmt;
  logic [4:0]  rd_r;
  logic [4:0]  q_r;
  logic [31:0] v_r;
  logic        mis;

  int checks;
  int errors;

  register_file dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .rdy                           (rdy),
    .rs1_from_dispatcher           (rs1),
    .rs2_from_dispatcher           (rs2),
    .Q1_to_dispatcher              (q1),
    .Q2_to_dispatcher              (q2),
    .V1_to_dispatcher              (v1),
    .V2_to_dispatcher              (v2),
    .rename_signal_from_dispatcher (ren),
    .rd_from_dispatcher            (rd_d),
    .rob_id_from_dispatcher        (rob_id),
    .commit_flag_from_rob          (cmt),
    .rd_from_rob                   (rd_r),
    .Q_from_rob                    (q_r),
    .V_from_rob                    (v_r),
    .misbranch_flag_from_rob       (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    ren    = 1'b0;
    rd_d   = '0;
    rob_id = '0;
    cmt    = 1'b0;
    rd_r   = '0;
    q_r    = '0;
    v_r    = '0;
    mis    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rdy   = 1'b1;
    rst_n = 1'b0;
    rs1   = 5'd5;
    rs2   = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q1 !== 5'd0) begin
      errors++;
      $display("FAIL reset_q1 got %0d want 0", q1);
    end
    checks++;
    if (v1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_v1 got %0h want 0", v1);
    end
    checks++;
    if (q2 !== 5'd0) begin
      errors++;
      $display("FAIL reset_q2 got %0d want 0", q2);
    end
    checks++;
    if (v2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_v2 got %0h want 0", v2);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_commit_bypass();
    ren = 1'b1; rd_d = 5'd5; rob_id = 5'd3;
    step();
    rs1 = 5'd5;
    #1;
    checks++;
    if (q1 !== 5'd3) begin
      errors++;
      $display("FAIL renamed_q got %0d want 3", q1);
    end
    cmt = 1'b1; rd_r = 5'd5; q_r = 5'd3; v_r = 32'h1234;
    #1;
    checks++;
    if (q1 !== 5'd0) begin
      errors++;
      $display("FAIL bypass_q got %0d want 0", q1);
    end
    checks++;
    if (v1 !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_v got %0h want 1234", v1);
    end
    step();
    checks++;
    if (q1 !== 5'd0 || v1 !== 32'h1234) begin
      errors++;
      $display("FAIL commit_persist got q=%0d v=%0h want q=0 v=1234",
               q1, v1);
    end
  endtask

  task automatic test_newer_tag();
    ren = 1'b1; rd_d = 5'd5; rob_id = 5'd3;
    step();
    ren = 1'b1; rd_d = 5'd5; rob_id = 5'd7;
    step();
    cmt = 1'b1; rd_r = 5'd5; q_r = 5'd3; v_r = 32'hAA;
    rs2 = 5'd5;
    #1;
    checks++;
    if (q2 !== 5'd7) begin
      errors++;
      $display("FAIL stale_nobypass got q=%0d want 7", q2);
    end
    step();
    checks++;
    if (q2 !== 5'd7 || v2 !== 32'hAA) begin
      errors++;
      $display("FAIL newer_tag got q=%0d v=%0h want q=7 v=aa",
               q2, v2);
    end
  endtask

  task automatic test_misbranch();
    ren = 1'b1; rd_d = 5'd6; rob_id = 5'd4;
    step();
    ren = 1'b1; rd_d = 5'd7; rob_id = 5'd9;
    step();
    rs1 = 5'd6; rs2 = 5'd7;
    #1;
    checks++;
    if (q1 !== 5'd4 || q2 !== 5'd9) begin
      errors++;
      $display("FAIL pre_flush got q1=%0d q2=%0d want 4 9", q1, q2);
    end
    mis = 1'b1;
    ren = 1'b1; rd_d = 5'd8; rob_id = 5'd10;
    cmt = 1'b1; rd_r = 5'd9; q_r = 5'd12; v_r = 32'h77;
    step();
    checks++;
    if (q1 !== 5'd0 || q2 !== 5'd0) begin
      errors++;
      $display("FAIL flush_q67 got q1=%0d q2=%0d want 0 0", q1, q2);
    end
    rs1 = 5'd8; rs2 = 5'd9;
    #1;
    checks++;
    if (q1 !== 5'd0) begin
      errors++;
      $display("FAIL flush_drop_rename got %0d want 0", q1);
    end
    checks++;
    if (v2 !== 32'h77) begin
      errors++;
      $display("FAIL flush_commit_v got %0h want 77", v2);
    end
  endtask

  task automatic test_same_cycle_rename();
    cmt = 1'b1; rd_r = 5'd2; q_r = 5'd0; v_r = 32'h55;
    step();
    ren = 1'b1; rd_d = 5'd2; rob_id = 5'd2;
    rs1 = 5'd2;
    #1;
    checks++;
    if (q1 !== 5'd0 || v1 !== 32'h55) begin
      errors++;
      $display("FAIL pre_rename_read got q=%0d v=%0h want q=0 v=55",
               q1, v1);
    end
    step();
    checks++;
    if (q1 !== 5'd2) begin
      errors++;
      $display("FAIL post_rename_q got %0d want 2", q1);
    end
  endtask

  task automatic test_x0();
    cmt = 1'b1; rd_r = 5'd0; q_r = 5'd0; v_r = 32'hFFFF;
    ren = 1'b1; rd_d = 5'd0; rob_id = 5'd1;
    rs1 = 5'd0;
    #1;
    checks++;
    if (q1 !== 5'd0 || v1 !== 32'd0) begin
      errors++;
      $display("FAIL x0_same got q=%0d v=%0h want 0 0", q1, v1);
    end
    step();
    checks++;
    if (q1 !== 5'd0 || v1 !== 32'd0) begin
      errors++;
      $display("FAIL x0_after got q=%0d v=%0h want 0 0", q1, v1);
    end
  endtask

  task automatic test_commit_rename_same_rd();
    ren = 1'b1; rd_d = 5'd11; rob_id = 5'd6;
    step();
    cmt = 1'b1; rd_r = 5'd11; q_r = 5'd6; v_r = 32'h99;
    ren = 1'b1; rd_d = 5'd11; rob_id = 5'd8;
    step();
    rs2 = 5'd11;
    #1;
    checks++;
    if (q2 !== 5'd8 || v2 !== 32'h99) begin
      errors++;
      $display("FAIL cmt_ren_same got q=%0d v=%0h want q=8 v=99",
               q2, v2);
    end
  endtask

  task automatic test_rdy_stall();
    rdy = 1'b0;
    ren = 1'b1; rd_d = 5'd10; rob_id = 5'd5;
    cmt = 1'b1; rd_r = 5'd12; q_r = 5'd0; v_r = 32'hBEEF;
    step();
    rs1 = 5'd10; rs2 = 5'd12;
    #1;
    checks++;
    if (q1 !== 5'd0 || v2 !== 32'd0) begin
      errors++;
      $display("FAIL stall_hold got q1=%0d v2=%0h want 0 0", q1, v2);
    end
    rdy = 1'b1;
    ren = 1'b1; rd_d = 5'd10; rob_id = 5'd5;
    step();
    checks++;
    if (q1 !== 5'd5) begin
      errors++;
      $display("FAIL stall_resume got %0d want 5", q1);
    end
  endtask

  task automatic test_async_reset();
    rs1 = 5'd5; rs2 = 5'd11;
    ren = 1'b1; rd_d = 5'd5; rob_id = 5'd13;
    cmt = 1'b1; rd_r = 5'd11; q_r = 5'd8; v_r = 32'h4242;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q1 !== 5'd0 || v1 !== 32'd0 || v2 !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got q1=%0d v1=%0h v2=%0h want 0",
               q1, v1, v2);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    checks++;
    if (q1 !== 5'd0 || v1 !== 32'd0 || q2 !== 5'd0 || v2 !== 32'd0)
    begin
      errors++;
      $display("FAIL reset_override got q1=%0d v1=%0h q2=%0d v2=%0h",
               q1, v1, q2, v2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rs1 = '0;
    rs2 = '0;
    test_reset();
    test_commit_bypass();
    test_newer_tag();
    test_misbranch();
    test_same_cycle_rename();
    test_x0();
    test_commit_rename_same_rd();
    test_rdy_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
